// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the FFT result readout path.
// Holds the FFT size, the word widths, the readout FSM encoding and the bit-reverse helper.
package fft_pkg;

  localparam int LOG2N = 10;
  localparam int DW    = 16;
  localparam int NBINS = 512;
  localparam int MW    = 2 * DW + 1;
  localparam int FW    = LOG2N + MW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef logic [LOG2N-1:0] addr_t;
  typedef logic [MW-1:0]    mag_t;

  typedef struct packed {
    addr_t bin;
    mag_t  mag;
  } bin_word_t;

  function automatic addr_t bitrev(input addr_t a);
    addr_t r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_result_reader_if.sv
// Control, result-RAM read port and magnitude stream of the FFT result reader.
interface fft_result_reader_if;
  import fft_pkg::*;

  logic                start_i;
  logic                bank_i;
  logic                busy_o;
  logic                done_o;
  logic                rd_en_o;
  logic                rd_bank_o;
  addr_t               rd_addr_o;
  logic [2*DW-1:0]     rd_data_i;
  logic                valid_o;
  logic                ready_i;
  addr_t               bin_o;
  mag_t                mag_o;

  modport slave (
    input  start_i, bank_i, rd_data_i, ready_i,
    output busy_o, done_o, rd_en_o, rd_bank_o, rd_addr_o, valid_o, bin_o, mag_o
  );

  modport master (
    output start_i, bank_i, rd_data_i, ready_i,
    input  busy_o, done_o, rd_en_o, rd_bank_o, rd_addr_o, valid_o, bin_o, mag_o
  );

endinterface

// File: rtl/fft_out_fifo.sv
// Four-entry synchronous FIFO holding {bin, magnitude} words ahead of the output stream.
module fft_out_fifo
  import fft_pkg::*;
#(
  parameter int W = FW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [2:0]   count
);

  logic [W-1:0] mem_q [4];
  logic [1:0]   wr_ptr_q, wr_ptr_d;
  logic [1:0]   rd_ptr_q, rd_ptr_d;
  logic [2:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {1'b0, push};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    count_d  = count_q + {2'b0, push} - {2'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only observable once count says it was written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fft_result_reader.sv
// Reads the final FFT bank in bit-reversed order, squares each bin to a magnitude
// and streams bins 0..NBINS-1 in natural order over a valid/ready handshake.
module fft_result_reader
  import fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fft_result_reader_if.slave   bus
);

  localparam addr_t LAST_BIN = addr_t'(NBINS - 1);

  logic [1:0] state_q, state_d;
  logic       bank_q, bank_d;
  addr_t      k_q, k_d;
  addr_t      out_cnt_q, out_cnt_d;
  logic       rd_en_q, rd_en_d;
  logic       rd_bank_q, rd_bank_d;
  addr_t      rd_addr_q, rd_addr_d;
  addr_t      rd_bin_q, rd_bin_d;
  logic       rsp_vld_q, rsp_vld_d;
  addr_t      rsp_bin_q, rsp_bin_d;
  logic       done_q, done_d;

  logic                   fifo_valid;
  logic [2:0]             fifo_count;
  bin_word_t              head;
  bin_word_t              push_word;
  logic                   pop;
  logic                   issue;
  logic [3:0]             occ;
  logic signed [DW-1:0]   re, im;
  logic signed [2*DW-1:0] sq_re, sq_im;
  mag_t                   mag;

  // Both squares are non-negative, so zero-extending each before the add cannot overflow.
  always_comb begin
    re        = bus.rd_data_i[2*DW-1:DW];
    im        = bus.rd_data_i[DW-1:0];
    sq_re     = re * re;
    sq_im     = im * im;
    mag       = {1'b0, sq_re} + {1'b0, sq_im};
    push_word = '{bin: rsp_bin_q, mag: mag};
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    pop   = fifo_valid & bus.ready_i;
    occ   = {1'b0, fifo_count} + {3'b0, rd_en_q} + {3'b0, rsp_vld_q};
    issue = (state_q == S_READ) && (occ < (4'd4 + {3'b0, pop}));

    state_d   = state_q;
    bank_d    = bank_q;
    k_d       = k_q;
    out_cnt_d = out_cnt_q;
    rd_en_d   = 1'b0;
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    rd_bin_d  = rd_bin_q;
    rsp_vld_d = rd_en_q;
    rsp_bin_d = rd_bin_q;
    done_d    = 1'b0;

    if (pop) out_cnt_d = out_cnt_q + addr_t'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          bank_d    = bus.bank_i;
          k_d       = '0;
          out_cnt_d = '0;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        if (issue) begin
          rd_en_d   = 1'b1;
          rd_addr_d = bitrev(k_q);
          rd_bank_d = bank_q;
          rd_bin_d  = k_q;
          k_d       = k_q + addr_t'(1);
          if (k_q == LAST_BIN) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && out_cnt_q == LAST_BIN) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bank_q    <= 1'b0;
      k_q       <= '0;
      out_cnt_q <= '0;
      rd_en_q   <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      rd_bin_q  <= '0;
      rsp_vld_q <= 1'b0;
      rsp_bin_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      k_q       <= k_d;
      out_cnt_q <= out_cnt_d;
      rd_en_q   <= rd_en_d;
      rd_bank_q <= rd_bank_d;
      rd_addr_q <= rd_addr_d;
      rd_bin_q  <= rd_bin_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_bin_q <= rsp_bin_d;
      done_q    <= done_d;
    end
  end

  fft_out_fifo #(.W(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_vld_q),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count)
  );

  assign fifo_valid    = (fifo_count != 3'd0);
  assign bus.valid_o   = fifo_valid;
  assign bus.bin_o     = fifo_valid ? head.bin : '0;
  assign bus.mag_o     = fifo_valid ? head.mag : '0;
  assign bus.busy_o    = (state_q != S_IDLE);
  assign bus.done_o    = done_q;
  assign bus.rd_en_o   = rd_en_q;
  assign bus.rd_bank_o = rd_bank_q;
  assign bus.rd_addr_o = rd_addr_q;

endmodule

// File: tb/tb_fft_result_reader.sv
// Bench for fft_result_reader: RAM model, queue-based expected-bin model and
// a per-cycle compare process, driven by directed frames.
module tb_fft_result_reader;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_result_reader_if bus ();

  fft_result_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] ram [2][1024];
  always @(posedge clk) if (bus.rd_en_o) bus.rd_data_i <= ram[bus.rd_bank_o][bus.rd_addr_o];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    int     bin;
    longint mag;
  } exp_t;

  exp_t   exp_q[$];
  int     frame_bank, exp_issue, issued, popped, first_rd_cyc, first_vld_cyc;
  int     addr_log [NBINS];
  longint got_mag  [NBINS];
  bit     prev_stall;
  logic [LOG2N-1:0] prev_bin;
  logic [MW-1:0]    prev_mag;

  function automatic int brev(input int k);
    int r = 0;
    for (int i = 0; i < LOG2N; i++) if ((k >> i) & 1) r |= 1 << (LOG2N - 1 - i);
    return r;
  endfunction

  function automatic longint sqmag(input logic [31:0] w);
    longint re = $signed(w[31:16]);
    longint im = $signed(w[15:0]);
    return re * re + im * im;
  endfunction

  task automatic arm_frame(input int bank);
    exp_t e;
    exp_q.delete();
    for (int k = 0; k < NBINS; k++) begin
      e.bin = k;
      e.mag = sqmag(ram[bank][brev(k)]);
      exp_q.push_back(e);
    end
    frame_bank    = bank;
    exp_issue     = 0;
    issued        = 0;
    popped        = 0;
    first_rd_cyc  = -1;
    first_vld_cyc = -1;
    prev_stall    = 0;
  endtask

  // Compare process: inputs settle at the falling edge, so sample just after it.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst !== 1'b0) begin
      prev_stall = 0;
    end else begin
      if (bus.rd_en_o) begin
        if (exp_issue >= NBINS) begin
          check("read_past_end", exp_issue, NBINS - 1);
        end else begin
          check("rd_addr", bus.rd_addr_o, brev(exp_issue));
          check("rd_bank", bus.rd_bank_o, frame_bank);
          addr_log[exp_issue] = bus.rd_addr_o;
          if (exp_issue == 0) first_rd_cyc = cyc;
          exp_issue++;
        end
        issued++;
      end
      if (bus.busy_o) check("outstanding_le4", (issued - popped) <= 4, 1);
      if (prev_stall) begin
        check("stall_valid", bus.valid_o, 1);
        check("stall_bin", bus.bin_o, prev_bin);
        check("stall_mag", bus.mag_o, prev_mag);
      end
      if (bus.valid_o) begin
        if (first_vld_cyc < 0) first_vld_cyc = cyc;
        if (bus.ready_i) begin
          if (exp_q.size() == 0) begin
            check("bin_past_end", popped, NBINS - 1);
          end else begin
            e = exp_q.pop_front();
            check("bin", bus.bin_o, e.bin);
            check("mag", bus.mag_o, e.mag);
            got_mag[e.bin] = bus.mag_o;
          end
          popped++;
        end
      end
      prev_stall = bus.valid_o && !bus.ready_i;
      prev_bin   = bus.bin_o;
      prev_mag   = bus.mag_o;
    end
  end

  task automatic pulse_start(input int b, output int t);
    bus.start_i = 1'b1;
    bus.bank_i  = 1'(b);
    @(negedge clk);
    t = cyc;
    bus.start_i = 1'b0;
    bus.bank_i  = 1'(~b);
  endtask

  task automatic wait_done(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done_o) begin
        t = cyc;
        return;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_done"}, bus.done_o, 0);
    check({tag, "_rd_en"}, bus.rd_en_o, 0);
    check({tag, "_rd_bank"}, bus.rd_bank_o, 0);
    check({tag, "_rd_addr"}, bus.rd_addr_o, 0);
    check({tag, "_valid"}, bus.valid_o, 0);
    check({tag, "_bin"}, bus.bin_o, 0);
    check({tag, "_mag"}, bus.mag_o, 0);
  endtask

  initial begin
    int t0, t;
    bit seen;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.bank_i  = 1'b0;
    bus.ready_i = 1'b1;
    for (int k = 0; k < 1024; k++) begin
      ram[1][brev(k)] = {16'(k), 16'h0000};
      ram[0][k]       = $urandom;
    end
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Frame 1: ramp in bank 1, ready always high.
    arm_frame(1);
    pulse_start(1, t0);
    wait_done(2000, t);
    check("f1_done_cycle", t, t0 + 515);
    check("f1_first_rd", first_rd_cyc, t0 + 1);
    check("f1_first_valid", first_vld_cyc, t0 + 3);
    check("f1_addr0", addr_log[0], 0);
    check("f1_addr1", addr_log[1], 512);
    check("f1_addr2", addr_log[2], 256);
    check("f1_addr3", addr_log[3], 768);
    check("f1_addr511", addr_log[511], 1022);
    check("f1_mag3", got_mag[3], 9);
    check("f1_mag511", got_mag[511], 261121);
    check("f1_popped", popped, NBINS);
    check("f1_busy_at_done", bus.busy_o, 0);
    @(negedge clk);
    check("f1_done_pulse", bus.done_o, 0);

    // Frame 2: extremes in bank 0, start pulsed during READ and DRAIN.
    ram[0][brev(0)] = {16'h8000, 16'h8000};
    ram[0][brev(1)] = {16'h7fff, 16'h8000};
    arm_frame(0);
    pulse_start(0, t0);
    repeat (40) @(negedge clk);
    bus.start_i = 1'b1;
    bus.bank_i  = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("f2_busy_read", bus.busy_o, 1);
    for (int i = 0; i < 1000 && issued < NBINS; i++) @(negedge clk);
    check("f2_all_issued", issued, NBINS);
    bus.ready_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("f2_drain_valid", bus.valid_o, 1);
    bus.ready_i = 1'b1;
    wait_done(200, t);
    check("f2_done_seen", t >= 0, 1);
    check("f2_mag_min_min", got_mag[0], 64'd2147483648);
    check("f2_mag_max_min", got_mag[1], 64'd2147418113);
    check("f2_popped", popped, NBINS);
    repeat (5) @(negedge clk);
    check("f2_idle", bus.busy_o, 0);

    // Frame 3: random backpressure with a 20-cycle hold-off.
    for (int k = 0; k < 1024; k++) ram[0][k] = $urandom;
    arm_frame(0);
    pulse_start(0, t0);
    seen = 0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      bus.ready_i = (i >= 100 && i < 120) ? 1'b0 : 1'($urandom_range(0, 1));
      if (i == 119) begin
        check("f3_stall_full", issued - popped, 4);
        check("f3_stall_valid", bus.valid_o, 1);
      end
      @(negedge clk);
      if (bus.done_o) seen = 1;
    end
    bus.ready_i = 1'b1;
    check("f3_done_seen", seen, 1);
    check("f3_popped", popped, NBINS);
    check("f3_queue_empty", exp_q.size(), 0);
    @(negedge clk);

    // Frame 4: reset mid-frame, then a fresh full frame.
    arm_frame(1);
    pulse_start(1, t0);
    for (int i = 0; i < 20 && !bus.valid_o; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("f4_pre_reset_valid", bus.valid_o, 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("f4_reset");
    rst = 1'b0;
    arm_frame(0);
    repeat (2) @(negedge clk);
    pulse_start(0, t0);
    wait_done(2000, t);
    check("f4_done_cycle", t, t0 + 515);
    check("f4_first_valid", first_vld_cyc, t0 + 3);
    check("f4_popped", popped, NBINS);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_result_reader.md
# fft_result_reader

Streams the finished 1024-point FFT spectrum out of the ping-pong result RAM after the last butterfly stage completes. Reads the bank holding the final stage in bit-reversed address order so bins leave in natural order 0..NBINS-1. Converts each complex word to squared magnitude and presents it on a valid/ready stream to the display/averaging path.

## Interface
- LOG2N, 10, log2 of FFT size; RAM address width
- DW, 16, signed width of each of re/im in a RAM word
- NBINS, 512, bins emitted per frame (first half of spectrum); must be ≤ 2^LOG2N
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start_i  in  1  one-cycle pulse: begin readout of one frame
- bank_i  in  1  bank holding final FFT result; sampled only with accepted start_i
- busy_o  out  1  high from accepted start_i until the last bin handshakes
- done_o  out  1  one-cycle pulse on the cycle after the last bin handshakes
- rd_en_o  out  1  RAM read strobe
- rd_bank_o  out  1  bank select for the read
- rd_addr_o  out  LOG2N  RAM read address
- rd_data_i  in  2*DW  {re, im}, two's complement, valid exactly one cycle after rd_en_o
- valid_o  out  1  output bin valid
- ready_i  in  1  downstream ready
- bin_o  out  LOG2N  bin index of current output
- mag_o  out  2*DW+1  re²+im², unsigned

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE: start_i=1 → latch bank_i, clear issue counter k and output counter, busy_o=1, go READ. start_i outside IDLE ignored.
- READ: each cycle a read is issued iff credit available: (fifo_count + inflight − pop) < 4, where pop = valid_o & ready_i. On issue: rd_en_o=1, rd_addr_o=bitrev_LOG2N(k), rd_bank_o=latched bank, k++. After issuing k=NBINS−1 → DRAIN.
- Return path: cycle after issue, compute re²+im² (signed DW×DW products, sum zero-extended to 2DW+1; −2^(DW−1) on both gives 2^(2DW−1), no overflow) and write {bin, mag} into a 4-entry FIFO. bin = issue index carried alongside the read.
- FIFO head drives valid_o/bin_o/mag_o; entry pops on valid_o & ready_i. Push and pop same cycle allowed, count unchanged.
- DRAIN: no reads; when bin NBINS−1 handshakes → IDLE, busy_o=0, done_o pulses next cycle.
- valid_o, bin_o, mag_o stable while valid_o & !ready_i. FIFO never overflows by credit rule; no data dropped.
- rst in any state: FSM→IDLE, FIFO and counters cleared, in-flight read data discarded.

## Timing
- Reset values: busy_o=0, done_o=0, rd_en_o=0, rd_bank_o=0, rd_addr_o=0, valid_o=0, bin_o=0, mag_o=0.
- start_i at cycle T → first rd_en_o at T+1 (addr 0), first valid_o at T+3.
- ready_i held high: one bin per cycle, frame of NBINS bins takes NBINS+3 cycles start to done_o.
- rd_en_o, rd_addr_o, rd_bank_o registered; rd_addr_o/rd_bank_o hold last value when rd_en_o=0.
- ready_i low: issuance stalls within 2 cycles; at most 4 entries buffered.

## Structure
- Shared package fft_pkg: LOG2N, DW, NBINS defaults, bitrev function, FSM state encoding.
- One sub-module: fft_out_fifo (4-entry synchronous FIFO, width LOG2N+2*DW+1, count output, sync active-high reset).
- Squaring/sum in the top level, single register stage into FIFO.

## Test plan
- Bank 1 preloaded with word at addr bitrev(k) = {re=k, im=0}; start_i, ready_i=1 → bins 0..511 in order, mag_o=k², one per cycle, first valid_o at T+3, done_o at T+515.
- Address check: rd_addr_o sequence starts 0, 512, 256, 768; k=511 → 1022; rd_bank_o=1 throughout.
- Extremes: re=im=−32768 → mag_o=2147483648; re=32767, im=−32768 → 2147418113.
- Backpressure: ready_i toggles pseudo-randomly, held low 20 cycles → no loss/duplication, ≤4 reads outstanding beyond accepted bins, outputs stable while stalled.
- start_i pulsed during READ and DRAIN → ignored; bank/sequence unchanged.
- rst asserted mid-frame with valid_o high → next cycle all outputs 0, FSM IDLE; fresh start_i produces full frame from bin 0.
